adsr_voice_scheduler: RTL and testbench
=======================================

Name: adsr_voice_scheduler

Overview:
Drives the control side of the RAM-based 8-voice ADSR envelope block. It produces the time-multiplexed voice select, the two per-slot enable strobes (compute, then write-back) and the per-voice GATE. It also turns note-on/note-off commands from the MIDI front end into per-voice gate and note assignments, using lowest-free-voice allocation and oldest-voice stealing.

Parameters:
VOICES, 8, number of voices; must be a power of 2.
SEL_W, 3, log2(VOICES).
SLOT_CYCLES, 16, clocks per voice slot; minimum 4.
FRAME_CYCLES, 1024, clocks per full scan (sample period); must be >= VOICES*SLOT_CYCLES.

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  note command present
cmd_ready  out  1  scheduler can accept a command this cycle
cmd_on  in  1  1 = note-on, 0 = note-off
cmd_note  in  7  MIDI note number
sel  out  SEL_W  voice currently being serviced
ena0  out  1  envelope compute strobe for voice sel
ena1  out  1  envelope write-back strobe for voice sel
GATE  out  1  gate of voice sel (gates[sel])
note  out  7  note assigned to voice sel, for the pitch generator
gates  out  VOICES  all voice gates, bit v = voice v

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high.
- Reset values: sel=0, ena0=0, ena1=0, gates=0, all notes=0, ages[v]=v (voice 0 is youngest), cmd_ready=1, frame counter=0, FSM=IDLE.
- Frame timing:
  - The frame counter runs 0..FRAME_CYCLES-1, then wraps to 0.
  - Slot index = count/SLOT_CYCLES while count < VOICES*SLOT_CYCLES; this drives sel.
  - After the last slot, sel holds at VOICES-1 with no strobes until the wrap.
  - ena0 is a single-cycle pulse at slot offset SLOT_CYCLES-3.
  - ena1 is a single-cycle pulse at slot offset SLOT_CYCLES-2.
  - ena0 and ena1 are never high together, and never high outside a slot.
  - sel advances on the cycle after offset SLOT_CYCLES-1.
- GATE and note are combinational reads of gates[sel] and note[sel]; they are stable for the whole slot except when a command updates that voice.
- Command FSM states: IDLE, SEARCH, UPDATE, STEAL_WAIT.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, register cmd_on and cmd_note, then go to SEARCH.
- SEARCH (1 cycle), decision on the registered command:
  - Note-on, note already held (gate=1 with same note): no change.
  - Note-on, otherwise: target = lowest-index voice with gate=0; if none, target = the voice with the highest age.
  - Note-off: target = the voice with gate=1 and matching note; if none, no change.
- UPDATE (1 cycle):
  - Note-on to a free voice: gates[t]=1, note[t]=cmd_note; t becomes age 0, and voices younger than t's old age increment. Return to IDLE.
  - Note-off: gates[t]=0, ages unchanged. Return to IDLE.
  - Steal: gates[t]=0, note[t]=cmd_note, go to STEAL_WAIT.
  - No change: return to IDLE.
- STEAL_WAIT:
  - cmd_ready=0.
  - Wait for an ena0 pulse with sel==t, so the envelope sees the gate low.
  - On the cycle after that pulse: gates[t]=1, LRU update as above, return to IDLE.
- Latency: a gate change is visible 3 cycles after the accept cycle. A steal takes at most FRAME_CYCLES+3 cycles.
- Ages always form a permutation of 0..VOICES-1.
- A command updating voice sel mid-slot is allowed. The new GATE is taken by the next ena0 for that voice.
- Reset asserted mid-steal or mid-frame: everything returns to reset values on the next edge; a pending steal is discarded.

Test Plan:
- Reset, then run 2 frames (FRAME_CYCLES=1024) -> sel steps 0..7 every 16 clocks; ena0 at count 13+16k, ena1 at 14+16k, k=0..7; no strobes at counts 128..1023.
- Note-on 60, 64, 67 -> voices 0, 1, 2 take them; gates=0x07; GATE=1 during slots 0-2; note reads 60/64/67.
- Note-off 64 -> gates=0x05 three cycles after accept. Note-off 99 (not held) -> gates unchanged, cmd_ready back high after 3 cycles.
- Note-on 60 while already held -> gates and ages unchanged.
- Fill all 8 voices with notes 40..47, then note-on 50 -> voice 0 (oldest) goes gate low; cmd_ready stays 0 until slot-0 ena0; gate returns high the next cycle with note 50.
- Assert reset during STEAL_WAIT -> next cycle gates=0, cmd_ready=1, sel=0, no ena pulses until count 13.

Source files
------------

// File: rtl/adsr_voice_scheduler_if.sv
// Note-command handshake between the MIDI front end (master) and the voice scheduler (slave).
interface adsr_voice_scheduler_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_on;
   logic [6:0] cmd_note;

   modport master (output cmd_valid, output cmd_on, output cmd_note, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_on, input cmd_note, output cmd_ready);
endinterface

// File: rtl/adsr_voice_scheduler.sv
// Voice slot sequencer and note-to-voice allocator for the 8-voice ADSR envelope block.
// Free voices are taken lowest-index first; when all are busy the oldest voice is stolen.
module adsr_voice_scheduler #(
   parameter int VOICES       = 8,
   parameter int SEL_W        = 3,
   parameter int SLOT_CYCLES  = 16,
   parameter int FRAME_CYCLES = 1024
) (
   input  logic                   clk,
   input  logic                   reset,
   adsr_voice_scheduler_if.slave  cmd,
   output logic [SEL_W-1:0]       sel,
   output logic                   ena0,
   output logic                   ena1,
   output logic                   GATE,
   output logic [6:0]             note,
   output logic [VOICES-1:0]      gates
);
   localparam int CNT_W    = $clog2(FRAME_CYCLES);
   localparam int OFF_W    = $clog2(SLOT_CYCLES);
   localparam int SCAN_END = VOICES * SLOT_CYCLES;

   typedef enum logic [1:0] {IDLE, SEARCH, UPDATE, STEAL_WAIT} state_t;
   typedef enum logic [1:0] {ACT_NONE, ACT_ON, ACT_OFF, ACT_STEAL} act_t;

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [OFF_W-1:0]  off_q, off_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   state_t            state_q, state_d;
   act_t              act_q, act_d;
   logic              cmd_on_q, cmd_on_d;
   logic [6:0]        cmd_note_q, cmd_note_d;
   logic [SEL_W-1:0]  tgt_q, tgt_d;
   logic [VOICES-1:0] gates_q, gates_d;
   logic [6:0]        note_q [VOICES];
   logic [6:0]        note_d [VOICES];
   logic [SEL_W-1:0]  age_q [VOICES];
   logic [SEL_W-1:0]  age_d [VOICES];

   logic              in_scan;
   logic              lru_touch;
   logic [VOICES-1:0] free_v, match_v, oldest_v;
   logic [SEL_W-1:0]  free_idx, match_idx, oldest_idx;

   // Frame sequencing: slot offset and voice index advance together; sel parks on the last voice.
   assign in_scan = int'(cnt_q) < SCAN_END;

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      off_d = off_q;
      sel_d = sel_q;
      if (cnt_q == CNT_W'(FRAME_CYCLES - 1)) begin
         cnt_d = '0;
         off_d = '0;
         sel_d = '0;
      end else begin
         off_d = (off_q == OFF_W'(SLOT_CYCLES - 1)) ? '0 : off_q + OFF_W'(1);
         if (in_scan && off_q == OFF_W'(SLOT_CYCLES - 1) && sel_q != SEL_W'(VOICES - 1))
            sel_d = sel_q + SEL_W'(1);
      end
   end

   assign sel   = sel_q;
   assign ena0  = in_scan && (off_q == OFF_W'(SLOT_CYCLES - 3));
   assign ena1  = in_scan && (off_q == OFF_W'(SLOT_CYCLES - 2));
   assign GATE  = gates_q[sel_q];
   assign note  = note_q[sel_q];
   assign gates = gates_q;
   assign cmd.cmd_ready = (state_q == IDLE);

   for (genvar gi = 0; gi < VOICES; gi++) begin : g_flag
      assign free_v[gi]   = ~gates_q[gi];
      assign match_v[gi]  = gates_q[gi] && (note_q[gi] == cmd_note_q);
      assign oldest_v[gi] = (age_q[gi] == SEL_W'(VOICES - 1));
   end

   // Scanning downwards leaves the lowest set index in each encoder.
   always_comb begin
      free_idx   = '0;
      match_idx  = '0;
      oldest_idx = '0;
      for (int i = VOICES - 1; i >= 0; i--) begin
         if (free_v[i])   free_idx   = SEL_W'(i);
         if (match_v[i])  match_idx  = SEL_W'(i);
         if (oldest_v[i]) oldest_idx = SEL_W'(i);
      end
   end

   always_comb begin
      state_d    = state_q;
      act_d      = act_q;
      cmd_on_d   = cmd_on_q;
      cmd_note_d = cmd_note_q;
      tgt_d      = tgt_q;
      gates_d    = gates_q;
      note_d     = note_q;
      age_d      = age_q;
      lru_touch  = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd.cmd_valid) begin
               cmd_on_d   = cmd.cmd_on;
               cmd_note_d = cmd.cmd_note;
               state_d    = SEARCH;
            end
         end
         SEARCH: begin
            act_d   = ACT_NONE;
            state_d = UPDATE;
            if (cmd_on_q) begin
               if (match_v == '0) begin
                  if (free_v != '0) begin
                     act_d = ACT_ON;
                     tgt_d = free_idx;
                  end else begin
                     act_d = ACT_STEAL;
                     tgt_d = oldest_idx;
                  end
               end
            end else if (match_v != '0) begin
               act_d = ACT_OFF;
               tgt_d = match_idx;
            end
         end
         UPDATE: begin
            state_d = IDLE;
            case (act_q)
               ACT_ON: begin
                  gates_d[tgt_q] = 1'b1;
                  note_d[tgt_q]  = cmd_note_q;
                  lru_touch      = 1'b1;
               end
               ACT_OFF: gates_d[tgt_q] = 1'b0;
               ACT_STEAL: begin
                  gates_d[tgt_q] = 1'b0;
                  note_d[tgt_q]  = cmd_note_q;
                  state_d        = STEAL_WAIT;
               end
               default: ;
            endcase
         end
         STEAL_WAIT: begin
            // Hold the stolen voice low until its envelope has computed once with GATE=0.
            if (ena0 && sel_q == tgt_q) begin
               gates_d[tgt_q] = 1'b1;
               lru_touch      = 1'b1;
               state_d        = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (lru_touch) begin
         for (int i = 0; i < VOICES; i++) begin
            if (SEL_W'(i) == tgt_q)
               age_d[i] = '0;
            else if (age_q[i] < age_q[tgt_q])
               age_d[i] = age_q[i] + SEL_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q      <= '0;
         off_q      <= '0;
         sel_q      <= '0;
         state_q    <= IDLE;
         act_q      <= ACT_NONE;
         cmd_on_q   <= 1'b0;
         cmd_note_q <= '0;
         tgt_q      <= '0;
         gates_q    <= '0;
         for (int i = 0; i < VOICES; i++) begin
            note_q[i] <= '0;
            age_q[i]  <= SEL_W'(i);
         end
      end else begin
         cnt_q      <= cnt_d;
         off_q      <= off_d;
         sel_q      <= sel_d;
         state_q    <= state_d;
         act_q      <= act_d;
         cmd_on_q   <= cmd_on_d;
         cmd_note_q <= cmd_note_d;
         tgt_q      <= tgt_d;
         gates_q    <= gates_d;
         note_q     <= note_d;
         age_q      <= age_d;
      end
   end
endmodule

// File: tb/tb_adsr_voice_scheduler.sv
// Directed bench for adsr_voice_scheduler: frame strobes, allocation, note-off, stealing, reset mid-steal.
module tb_adsr_voice_scheduler;
   localparam int FRAME = 1024;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] sel;
   logic       ena0, ena1, GATE;
   logic [6:0] note;
   logic [7:0] gates;

   int checks   = 0;
   int failures = 0;
   int fc       = 0;

   adsr_voice_scheduler_if cif();

   adsr_voice_scheduler #(
      .VOICES(8), .SEL_W(3), .SLOT_CYCLES(16), .FRAME_CYCLES(FRAME)
   ) dut (
      .clk(clk), .reset(reset), .cmd(cif),
      .sel(sel), .ena0(ena0), .ena1(ena1), .GATE(GATE), .note(note), .gates(gates)
   );

   always #10 clk = ~clk;

   // Advance one clock; fc tracks the expected frame count, sampling happens 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      if (reset) fc = 0;
      else       fc = (fc + 1) % FRAME;
      #1;
   endtask

   task automatic advance_to(input int target);
      while (fc != target) tick();
   endtask

   task automatic send(input logic on, input logic [6:0] n);
      int waited = 0;
      while (cif.cmd_ready !== 1'b1 && waited < 2000) begin
         tick();
         waited++;
      end
      checks++;
      if (cif.cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL send_wait_ready: cmd_ready=%b required=1 after %0d cycles", cif.cmd_ready, waited);
      end
      cif.cmd_valid = 1'b1;
      cif.cmd_on    = on;
      cif.cmd_note  = n;
      tick();
      cif.cmd_valid = 1'b0;
   endtask

   task automatic cmd3(input logic on, input logic [6:0] n);
      send(on, n);
      tick();
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cif.cmd_valid = 1'b0;
      cif.cmd_on    = 1'b0;
      cif.cmd_note  = '0;
      tick();
      tick();
      reset = 1'b0;
      checks++;
      if ({sel, ena0, ena1, GATE, note, gates, cif.cmd_ready} !== {3'd0, 1'b0, 1'b0, 1'b0, 7'd0, 8'h00, 1'b1}) begin
         failures++;
         $display("FAIL reset_state: sel=%0d ena0=%b ena1=%b GATE=%b note=%0d gates=%h ready=%b required 0/0/0/0/0/00/1",
                  sel, ena0, ena1, GATE, note, gates, cif.cmd_ready);
      end
   endtask

   task automatic test_frame();
      logic [2:0] exp_sel;
      logic       exp_e0, exp_e1;
      for (int c = 0; c < 2 * FRAME; c++) begin
         int k;
         k       = c % FRAME;
         exp_sel = (k < 128) ? 3'(k / 16) : 3'd7;
         exp_e0  = (k < 128) && (k % 16 == 13);
         exp_e1  = (k < 128) && (k % 16 == 14);
         checks++;
         if ({sel, ena0, ena1} !== {exp_sel, exp_e0, exp_e1}) begin
            failures++;
            $display("FAIL frame_timing count=%0d: sel=%0d ena0=%b ena1=%b required sel=%0d ena0=%b ena1=%b",
                     k, sel, ena0, ena1, exp_sel, exp_e0, exp_e1);
         end
         tick();
      end
   endtask

   task automatic test_note_on();
      logic [7:0] exp_g  [3];
      logic [6:0] notes  [3];
      logic       slot_g [4];
      logic [6:0] slot_n [4];
      exp_g  = '{8'h01, 8'h03, 8'h07};
      notes  = '{7'd60, 7'd64, 7'd67};
      slot_g = '{1'b1, 1'b1, 1'b1, 1'b0};
      slot_n = '{7'd60, 7'd64, 7'd67, 7'd0};
      for (int i = 0; i < 3; i++) begin
         cmd3(1'b1, notes[i]);
         checks++;
         if (gates !== exp_g[i]) begin
            failures++;
            $display("FAIL note_on_%0d gates: got %h required %h", notes[i], gates, exp_g[i]);
         end
      end
      for (int s = 0; s < 4; s++) begin
         advance_to(16 * s + 5);
         checks++;
         if ({sel, GATE, note} !== {3'(s), slot_g[s], slot_n[s]}) begin
            failures++;
            $display("FAIL slot_read_%0d: sel=%0d GATE=%b note=%0d required sel=%0d GATE=%b note=%0d",
                     s, sel, GATE, note, s, slot_g[s], slot_n[s]);
         end
      end
   endtask

   task automatic test_note_off();
      send(1'b0, 7'd64);
      tick();
      checks++;
      if ({gates, cif.cmd_ready} !== {8'h07, 1'b0}) begin
         failures++;
         $display("FAIL note_off_64_early: gates=%h ready=%b required 07/0", gates, cif.cmd_ready);
      end
      tick();
      checks++;
      if ({gates, cif.cmd_ready} !== {8'h05, 1'b1}) begin
         failures++;
         $display("FAIL note_off_64: gates=%h ready=%b required 05/1", gates, cif.cmd_ready);
      end
      send(1'b0, 7'd99);
      tick();
      checks++;
      if (cif.cmd_ready !== 1'b0) begin
         failures++;
         $display("FAIL note_off_99_busy: ready=%b required 0", cif.cmd_ready);
      end
      tick();
      checks++;
      if ({gates, cif.cmd_ready} !== {8'h05, 1'b1}) begin
         failures++;
         $display("FAIL note_off_99: gates=%h ready=%b required 05/1", gates, cif.cmd_ready);
      end
   endtask

   task automatic test_held();
      cmd3(1'b1, 7'd60);
      checks++;
      if (gates !== 8'h05) begin
         failures++;
         $display("FAIL held_note_on: gates=%h required 05", gates);
      end
      cmd3(1'b1, 7'd72);
      checks++;
      if (gates !== 8'h07) begin
         failures++;
         $display("FAIL refill_lowest_free: gates=%h required 07", gates);
      end
   endtask

   task automatic test_steal();
      int n, viol;
      logic found;
      test_reset();
      for (int i = 0; i < 8; i++) cmd3(1'b1, 7'(40 + i));
      checks++;
      if (gates !== 8'hFF) begin
         failures++;
         $display("FAIL fill_all: gates=%h required ff", gates);
      end
      cmd3(1'b1, 7'd50);
      checks++;
      if ({gates, cif.cmd_ready} !== {8'hFE, 1'b0}) begin
         failures++;
         $display("FAIL steal_start: gates=%h ready=%b required fe/0", gates, cif.cmd_ready);
      end
      n = 0; viol = 0; found = 1'b0;
      while (!found && n < 1200) begin
         if (ena0 && sel == 3'd0) found = 1'b1;
         else begin
            if (cif.cmd_ready !== 1'b0 || gates[0] !== 1'b0) viol++;
            tick();
            n++;
         end
      end
      checks++;
      if (!found || fc != 13) begin
         failures++;
         $display("FAIL steal_wait_pulse: found=%b count=%0d required found=1 count=13", found, fc);
      end
      checks++;
      if (viol != 0) begin
         failures++;
         $display("FAIL steal_wait_hold: %0d cycles with ready or gate0 high, required 0", viol);
      end
      checks++;
      if ({GATE, note} !== {1'b0, 7'd50}) begin
         failures++;
         $display("FAIL steal_pulse_read: GATE=%b note=%0d required 0/50", GATE, note);
      end
      tick();
      checks++;
      if ({gates, cif.cmd_ready, GATE, note} !== {8'hFF, 1'b1, 1'b1, 7'd50}) begin
         failures++;
         $display("FAIL steal_done: gates=%h ready=%b GATE=%b note=%0d required ff/1/1/50",
                  gates, cif.cmd_ready, GATE, note);
      end
      cmd3(1'b1, 7'd51);
      checks++;
      if ({gates, cif.cmd_ready} !== {8'hFD, 1'b0}) begin
         failures++;
         $display("FAIL second_steal_oldest: gates=%h ready=%b required fd/0", gates, cif.cmd_ready);
      end
   endtask

   task automatic test_reset_mid_steal();
      int bad;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({gates, cif.cmd_ready, sel, ena0, ena1} !== {8'h00, 1'b1, 3'd0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset_mid_steal: gates=%h ready=%b sel=%0d ena0=%b ena1=%b required 00/1/0/0/0",
                  gates, cif.cmd_ready, sel, ena0, ena1);
      end
      bad = 0;
      while (fc < 13) begin
         if (ena0 !== 1'b0 || ena1 !== 1'b0) bad++;
         tick();
      end
      checks++;
      if (bad != 0 || ena0 !== 1'b1) begin
         failures++;
         $display("FAIL reset_strobe_restart: early strobes=%0d ena0@13=%b required 0/1", bad, ena0);
      end
      advance_to(30);
      checks++;
      if ({gates, note} !== {8'h00, 7'd0}) begin
         failures++;
         $display("FAIL steal_discarded: gates=%h note=%0d required 00/0", gates, note);
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_note_on();
      test_note_off();
      test_held();
      test_steal();
      test_reset_mid_steal();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
